seq_divider: RTL and testbench

Iterative unsigned restoring divider, one quotient bit per clock, with a start/done handshake. It is the inverse arithmetic unit to the combinational multiplier and is shared by the vital-sign processing datapath for averages and ratios (e.g. sum/count, beats per window). It trades latency for area: there is one subtractor, reused WIDTH times.

---
 rtl/div_pkg.sv | 31 +++
 rtl/seq_divider_step.sv | 36 +++
 rtl/seq_divider.sv | 142 ++++++++++++++
 tb/tb_seq_divider.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider:
//   - state_t            : divider FSM states (IDLE, RUN, DONE)
//   - DIV_WIDTH_DEFAULT  : default operand width
//   - clog2()            : width of the step counter for a given operand width
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DIV_WIDTH_DEFAULT = 32'sd8;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 32'sd0;
        v   = value - 32'sd1;
        while (v > 32'sd0) begin
            res = res + 32'sd1;
            v   = v >>> 1;
        end
        return (res < 32'sd1) ? 32'sd1 : res;
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_i     : current partial remainder (always < divisor, so WIDTH bits)
//   bit_i     : next dividend bit shifted in (MSB first)
//   divisor_i : divisor
//   rem_o     : next partial remainder
//   qbit_o    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted_s;

    // Shift in the next bit and conditionally subtract. The compare is done
    // on WIDTH+1 bits so it cannot overflow; the subtraction itself can stay
    // WIDTH bits because the true difference is always below the divisor.
    always_comb begin
        shifted_s = {rem_i, bit_i};
        if (shifted_s >= {1'b0, divisor_i}) begin
            qbit_o = 1'b1;
            rem_o  = shifted_s[WIDTH-1:0] - divisor_i;
        end else begin
            qbit_o = 1'b0;
            rem_o  = shifted_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk, rst            : clock, synchronous active-high reset
//   start               : request a division (accepted when busy=0)
//   dividend, divisor   : operands, sampled on the accept edge only
//   busy                : division in progress
//   done                : one-cycle pulse, results valid from this cycle
//   quotient, remainder : results, held until the next result or reset
//   div_by_zero         : divisor was zero (quotient all ones, remainder=dividend)
// All outputs are registered.
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;     // latched divisor
    logic [WIDTH-1:0] shq_q, shq_d;     // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmo_q, rmo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem_s;
    logic             step_bit_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (shq_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_s),
        .qbit_o    (step_bit_s)
    );

    // Next-state and datapath logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        shq_d   = shq_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmo_d   = rmo_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvs_d = divisor;
                    shq_d = dividend;
                    rem_d = {WIDTH{1'b0}};
                    cnt_d = {CNT_W{1'b0}};
                    if (divisor == {WIDTH{1'b0}}) begin
                        // Zero divisor short-circuits straight to DONE.
                        state_d = DONE;
                        done_d  = 1'b1;
                        quo_d   = {WIDTH{1'b1}};
                        rmo_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shq_d = {shq_q[WIDTH-2:0], step_bit_s};
                rem_d = step_rem_s;
                cnt_d = cnt_q + CNT_W'(1'b1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last step: publish results directly from the step output.
                    state_d = DONE;
                    done_d  = 1'b1;
                    quo_d   = {shq_q[WIDTH-2:0], step_bit_s};
                    rmo_d   = step_rem_s;
                    dbz_d   = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            shq_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            rmo_q   <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            shq_q   <= shq_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmo_q   <= rmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider (WIDTH=8). Stimulus pushes the expected
// result; a negedge monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_done   = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] q, input logic [7:0] r, input logic z);
        exp_t e;
        e.q = q;
        e.r = r;
        e.z = z;
        sb.push_back(e);
        n_pushed++;
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                check("done_without_request", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.z);
            end
        end
    end

    // One division: returns edge index of done rise and cycles busy was high.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic ez,
                           input int exp_edge, input string name);
        int got;
        int busy_cnt;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        push(eq, er, ez);
        @(posedge clk);                 // E0
        #1;
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h5A;
        got      = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 20 && got < 0; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) got = i - 1;
        end
        check({name, "_latency"}, got, exp_edge);
        check({name, "_busy_cycles"}, busy_cnt, exp_edge);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d1;
        int d2;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div(8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 8, "d100_7");
        run_div(8'd5,   8'd0,   8'd255, 8'd5, 1'b1, 0, "d5_0");
        run_div(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 8, "d255_1");
        run_div(8'd3,   8'd9,   8'd0,   8'd3, 1'b0, 8, "d3_9");
        run_div(8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 8, "d255_255");
        run_div(8'd0,   8'd13,  8'd0,   8'd0, 1'b0, 8, "d0_13");

        // start while busy must be ignored
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd10;
        push(8'd20, 8'd0, 1'b0);
        @(posedge clk);                 // E0
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(posedge clk);                 // E3
        #1;
        start = 1'b0;
        d1 = -1;
        for (int i = 4; i <= 20 && d1 < 0; i++) begin
            @(negedge clk);
            if (done === 1'b1) d1 = i - 1;
        end
        check("busy_start_latency", d1, 8);
        repeat (12) @(posedge clk);     // monitor flags any second done
        #1;

        // reset mid-operation (previous result 20 r 0 is nonzero)
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd10;
        @(posedge clk);                 // E0
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);                 // E4
        #1;
        rst = 1'b0;
        check("abort_quotient", quotient, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (12) @(posedge clk);
        #1;
        run_div(8'd50, 8'd7, 8'd7, 8'd1, 1'b0, 8, "d50_7");

        // back-to-back with start held high
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        push(8'd14, 8'd2, 1'b0);
        @(posedge clk);                 // E0
        #1;
        dividend = 8'd81;
        divisor  = 8'd9;
        push(8'd9, 8'd0, 1'b0);
        d1 = -1;
        d2 = -1;
        for (int i = 1; i <= 30 && d2 < 0; i++) begin
            @(negedge clk);
            if (i == 10) start = 1'b0;
            if (i == 13) begin
                check("b2b_hold_quotient", quotient, 14);
                check("b2b_hold_remainder", remainder, 2);
            end
            if (done === 1'b1) begin
                if (d1 < 0) d1 = i - 1;
                else        d2 = i - 1;
            end
        end
        start = 1'b0;
        check("b2b_first_done", d1, 8);
        check("b2b_second_done", d2, 17);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        check("done_count", n_done, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
